uart_io: RTL and testbench

//  Serial I/O unit that services the execute stage's IN/OUT handshake (uart_wenable/uart_renable -> uart_wdone/uart_rdone).
//  OUT: serializes 1-4 bytes of uart_wd onto txd, 8N1.
//  IN: assembles a 32-bit word from 4 received bytes taken from an RX FIFO.

---
 rtl/uart_io.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_uart_io.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io.sv
// uart_io: serial unit serving the exec-stage IN/OUT handshake; 8N1 TX, RX FIFO and 32-bit IN word assembly.
// Build option: define UART_PARITY_EN for 8E1 frames (even parity bit between bit 7 and stop).
module uart_io #(
  parameter int CLK_PER_BIT = 868,
  parameter int RX_FIFO_AW  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        uart_wenable,
  input  logic [1:0]  uart_wsz,
  input  logic [31:0] uart_wd,
  output logic        uart_wdone,
  input  logic        uart_renable,
  output logic [31:0] uart_rd,
  output logic        uart_rdone,
  input  logic        rxd,
  output logic        txd,
  output logic        tx_busy,
  output logic        rx_overrun
);

  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam int DEPTH = 1 << RX_FIFO_AW;

  localparam logic [CW-1:0]         BIT_LAST  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0]         HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [RX_FIFO_AW:0]   PTR_ONE   = (RX_FIFO_AW + 1)'(1);

  localparam logic [2:0] TX_IDLE  = 3'd0;
  localparam logic [2:0] TX_START = 3'd1;
  localparam logic [2:0] TX_DATA  = 3'd2;
  localparam logic [2:0] TX_STOP  = 3'd4;
  localparam logic [2:0] TX_DONE  = 3'd5;
`ifdef UART_PARITY_EN
  localparam logic [2:0] TX_PAR   = 3'd3;
`endif

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] RX_PAR   = 3'd3;
`endif

  localparam logic [0:0] IN_IDLE    = 1'b0;
  localparam logic [0:0] IN_COLLECT = 1'b1;

  // ---------------- TX ----------------
  logic [2:0]    r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [1:0]    r_tx_idx;
  logic [31:0]   r_tx_word;
  logic [7:0]    r_tx_sh;
  logic          r_txd;
  logic          r_tx_busy;
  logic          r_wdone;
  logic [7:0]    w_tx_byte;
  logic          w_tx_bit_end;

  always_comb begin
    w_tx_byte = r_tx_word[7:0];
    case (r_tx_idx)
      2'd3:    w_tx_byte = r_tx_word[31:24];
      2'd2:    w_tx_byte = r_tx_word[23:16];
      2'd1:    w_tx_byte = r_tx_word[15:8];
      default: w_tx_byte = r_tx_word[7:0];
    endcase
  end

  assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_idx   <= '0;
      r_txd      <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_wdone    <= 1'b0;
    end else begin
      r_wdone <= 1'b0;
      if (r_tx_state != TX_IDLE && r_tx_state != TX_DONE)
        r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + CNT_ONE;
      case (r_tx_state)
        TX_IDLE: begin
          if (uart_wenable) begin
            r_tx_word  <= uart_wd;
            r_tx_idx   <= uart_wsz;
            r_txd      <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_sh    <= w_tx_byte;
            r_tx_bit   <= '0;
            r_txd      <= w_tx_byte[0];
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_txd      <= ^w_tx_byte;
              r_tx_state <= TX_PAR;
`else
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
`endif
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
              r_txd    <= r_tx_sh[1];
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PAR: begin
          if (w_tx_bit_end) begin
            r_txd      <= 1'b1;
            r_tx_state <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (w_tx_bit_end) begin
            // Next byte starts straight after the stop bit; byte 0 is the last one out.
            if (r_tx_idx == 2'd0) begin
              r_wdone    <= 1'b1;
              r_tx_state <= TX_DONE;
            end else begin
              r_tx_idx   <= r_tx_idx - 2'd1;
              r_txd      <= 1'b0;
              r_tx_state <= TX_START;
            end
          end
        end
        TX_DONE: begin
          r_tx_busy  <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- RX ----------------
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [2:0]    r_rx_state;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;
  logic          r_rx_push;
  logic          w_rx_sample;
`ifdef UART_PARITY_EN
  logic          r_rx_perr;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // Start bit is sampled half a bit in; every later sample is one full bit apart.
  assign w_rx_sample = (r_rx_state == RX_START) ? (r_rx_cnt == HALF_LAST) : (r_rx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_push  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_perr  <= 1'b0;
`endif
    end else begin
      r_rx_push <= 1'b0;
      if (r_rx_state != RX_IDLE)
        r_rx_cnt <= w_rx_sample ? '0 : r_rx_cnt + CNT_ONE;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2)
            r_rx_state <= RX_START;
        end
        RX_START: begin
          if (w_rx_sample) begin
            if (r_rx_s2) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_bit   <= '0;
              r_rx_state <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (w_rx_sample) begin
            r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
            if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
              r_rx_state <= RX_PAR;
`else
              r_rx_state <= RX_STOP;
`endif
            end else begin
              r_rx_bit <= r_rx_bit + 3'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (w_rx_sample) begin
            r_rx_perr  <= r_rx_s2 ^ (^r_rx_sh);
            r_rx_state <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (w_rx_sample) begin
`ifdef UART_PARITY_EN
            r_rx_push  <= r_rx_s2 & ~r_rx_perr;
            r_rx_perr  <= 1'b0;
`else
            r_rx_push  <= r_rx_s2;
`endif
            r_rx_state <= RX_IDLE;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]          r_fifo_mem [DEPTH];
  logic [RX_FIFO_AW:0] r_wptr, r_rptr;
  logic                r_overrun;
  logic                w_empty, w_full, w_pop, w_wr;
  logic [7:0]          w_fifo_rd;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[RX_FIFO_AW] != r_rptr[RX_FIFO_AW]) &&
                     (r_wptr[RX_FIFO_AW-1:0] == r_rptr[RX_FIFO_AW-1:0]);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_wr      = r_rx_push && (!w_full || w_pop);
  assign w_fifo_rd = r_fifo_mem[r_rptr[RX_FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr)
      r_fifo_mem[r_wptr[RX_FIFO_AW-1:0]] <= r_rx_sh;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)
        r_rptr <= r_rptr + PTR_ONE;
      if (r_rx_push && w_full && !w_pop)
        r_overrun <= 1'b1;
    end
  end

  // ---------------- IN word assembly ----------------
  logic [0:0]  r_in_state;
  logic [1:0]  r_in_cnt;
  logic [31:0] r_in_sh;
  logic [31:0] r_rd;
  logic        r_rdone;

  assign w_pop = (r_in_state == IN_COLLECT) && !w_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_in_state <= IN_IDLE;
      r_in_cnt   <= '0;
      r_rd       <= '0;
      r_rdone    <= 1'b0;
    end else begin
      r_rdone <= 1'b0;
      case (r_in_state)
        IN_IDLE: begin
          if (uart_renable) begin
            r_in_sh    <= '0;
            r_in_cnt   <= '0;
            r_in_state <= IN_COLLECT;
          end
        end
        IN_COLLECT: begin
          if (w_pop) begin
            r_in_sh  <= {r_in_sh[23:0], w_fifo_rd};
            r_in_cnt <= r_in_cnt + 2'd1;
            if (r_in_cnt == 2'd3) begin
              r_rd       <= {r_in_sh[23:0], w_fifo_rd};
              r_rdone    <= 1'b1;
              r_in_state <= IN_IDLE;
            end
          end
        end
        default: r_in_state <= IN_IDLE;
      endcase
    end
  end

  assign txd        = r_txd;
  assign tx_busy    = r_tx_busy;
  assign uart_wdone = r_wdone;
  assign uart_rd    = r_rd;
  assign uart_rdone = r_rdone;
  assign rx_overrun = r_overrun;

endmodule

// File: tb/tb_uart_io.sv
// Directed bench for uart_io at CLK_PER_BIT=8, RX_FIFO_AW=4; covers the UART_PARITY_EN build when defined.
module tb_uart_io;
  localparam int CPB = 8;
  localparam int AW  = 4;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk, rstn, uart_wenable, uart_renable, rxd;
  logic [1:0]  uart_wsz;
  logic [31:0] uart_wd, uart_rd;
  logic        uart_wdone, uart_rdone, txd, tx_busy, rx_overrun;

  int vectors = 0;
  int miscompares = 0;
  int wdone_cnt = 0;
  int rdone_cnt = 0;

  logic obs_txd [0:399];
  int   obs_done_c, obs_pulses, obs_busy_lo;
  logic obs_busy_after, obs_wdone_after;

  uart_io #(.CLK_PER_BIT(CPB), .RX_FIFO_AW(AW)) dut (
    .clk(clk), .rstn(rstn),
    .uart_wenable(uart_wenable), .uart_wsz(uart_wsz), .uart_wd(uart_wd), .uart_wdone(uart_wdone),
    .uart_renable(uart_renable), .uart_rd(uart_rd), .uart_rdone(uart_rdone),
    .rxd(rxd), .txd(txd), .tx_busy(tx_busy), .rx_overrun(rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (uart_wdone === 1'b1) wdone_cnt <= wdone_cnt + 1;
    if (uart_rdone === 1'b1) rdone_cnt <= rdone_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion before 2ms");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  // Reference serial bit k of an OUT transfer: highest selected byte first, LSB-first bits.
  function automatic logic exp_bit(input logic [1:0] wsz, input logic [31:0] wd, input int k);
    int byte_n, pos, idx;
    logic [7:0] b;
    byte_n = k / FB;
    pos    = k % FB;
    idx    = int'(wsz) - byte_n;
    b      = wd[8*idx +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == FB - 1) return 1'b1;
    return ^b;
  endfunction

  task automatic run_tx(input logic [1:0] wsz, input logic [31:0] wd, input int inject_c);
    int n;
    n = (int'(wsz) + 1) * FB * CPB;
    uart_wsz = wsz; uart_wd = wd; uart_wenable = 1'b1;
    tick();
    uart_wenable = 1'b0;
    obs_done_c = 0; obs_pulses = 0; obs_busy_lo = 0;
    for (int c = 1; c <= n + 1; c++) begin
      obs_txd[c] = txd;
      if (uart_wdone === 1'b1) begin
        obs_pulses++;
        if (obs_done_c == 0) obs_done_c = c;
      end
      if (tx_busy !== 1'b1) obs_busy_lo++;
      if (c == inject_c) begin
        uart_wd = 32'hFFFF_FFFF; uart_wsz = 2'd3; uart_wenable = 1'b1;
      end else begin
        uart_wenable = 1'b0;
      end
      tick();
    end
    uart_wenable = 1'b0;
    obs_busy_after  = tx_busy;
    obs_wdone_after = uart_wdone;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0; repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin rxd = b[i]; repeat (CPB) tick(); end
`ifdef UART_PARITY_EN
    rxd = ^b; repeat (CPB) tick();
`endif
    rxd = stop; repeat (CPB) tick();
    rxd = 1'b1;
  endtask

  task automatic read_word(output logic ok, output logic [31:0] w, output logic single);
    int t;
    uart_renable = 1'b1;
    tick();
    uart_renable = 1'b0;
    t = 0;
    while (uart_rdone !== 1'b1 && t < 40) begin tick(); t++; end
    ok = (uart_rdone === 1'b1);
    w  = uart_rd;
    tick();
    single = (uart_rdone === 1'b0) && (uart_rd === w);
  endtask

  task automatic test_reset();
    rstn = 1'b0; uart_wenable = 1'b0; uart_renable = 1'b0; rxd = 1'b1;
    uart_wsz = 2'd0; uart_wd = 32'h0;
    repeat (3) tick();
    vectors++; if (txd !== 1'b1)         begin miscompares++; $display("FAIL reset_txd: got %b expected 1", txd); end
    vectors++; if (uart_wdone !== 1'b0)  begin miscompares++; $display("FAIL reset_wdone: got %b expected 0", uart_wdone); end
    vectors++; if (uart_rdone !== 1'b0)  begin miscompares++; $display("FAIL reset_rdone: got %b expected 0", uart_rdone); end
    vectors++; if (uart_rd !== 32'h0)    begin miscompares++; $display("FAIL reset_rd: got %h expected 00000000", uart_rd); end
    vectors++; if (tx_busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    vectors++; if (rx_overrun !== 1'b0)  begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
    rstn = 1'b1;
    idle(4);
  endtask

  task automatic test_tx_single();
    run_tx(2'd0, 32'h0000_0041, -1);
    for (int k = 0; k < FB; k++) begin
      logic [CPB-1:0] got, exp;
      for (int j = 0; j < CPB; j++) got[j] = obs_txd[1 + k*CPB + j];
      exp = {CPB{exp_bit(2'd0, 32'h41, k)}};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL tx1_bit%0d: txd %b expected %b", k, got, exp); end
    end
    vectors++; if (obs_done_c != FB*CPB + 1) begin miscompares++; $display("FAIL tx1_wdone_cycle: got %0d expected %0d", obs_done_c, FB*CPB + 1); end
    vectors++; if (obs_pulses != 1)  begin miscompares++; $display("FAIL tx1_wdone_pulses: got %0d expected 1", obs_pulses); end
    vectors++; if (obs_busy_lo != 0) begin miscompares++; $display("FAIL tx1_busy: low for %0d cycles, expected 0", obs_busy_lo); end
    vectors++; if (obs_busy_after !== 1'b0 || obs_wdone_after !== 1'b0)
      begin miscompares++; $display("FAIL tx1_after: busy %b wdone %b expected 0 0", obs_busy_after, obs_wdone_after); end
  endtask

  task automatic test_tx_word();
    int w0, low;
    run_tx(2'd3, 32'h1234_5678, 100);
    for (int k = 0; k < 4*FB; k++) begin
      logic [CPB-1:0] got, exp;
      for (int j = 0; j < CPB; j++) got[j] = obs_txd[1 + k*CPB + j];
      exp = {CPB{exp_bit(2'd3, 32'h1234_5678, k)}};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL tx4_bit%0d: txd %b expected %b", k, got, exp); end
    end
    vectors++; if (obs_done_c != 4*FB*CPB + 1) begin miscompares++; $display("FAIL tx4_wdone_cycle: got %0d expected %0d", obs_done_c, 4*FB*CPB + 1); end
    vectors++; if (obs_pulses != 1)  begin miscompares++; $display("FAIL tx4_wdone_pulses: got %0d expected 1", obs_pulses); end
    vectors++; if (obs_busy_lo != 0) begin miscompares++; $display("FAIL tx4_busy: low for %0d cycles, expected 0", obs_busy_lo); end
    w0 = wdone_cnt; low = 0;
    repeat (40) begin tick(); if (txd !== 1'b1 || tx_busy !== 1'b0) low++; end
    vectors++; if (wdone_cnt != w0 || low != 0)
      begin miscompares++; $display("FAIL tx4_ignored_wenable: extra wdone %0d, active cycles %0d, expected 0 0", wdone_cnt - w0, low); end
  endtask

  task automatic test_back_to_back();
    run_tx(2'd1, 32'h0000_A5C3, -1);
    for (int k = 0; k < 2*FB; k++) begin
      logic [CPB-1:0] got, exp;
      for (int j = 0; j < CPB; j++) got[j] = obs_txd[1 + k*CPB + j];
      exp = {CPB{exp_bit(2'd1, 32'h0000_A5C3, k)}};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL b2b_a_bit%0d: txd %b expected %b", k, got, exp); end
    end
    vectors++; if (obs_done_c != 2*FB*CPB + 1) begin miscompares++; $display("FAIL b2b_a_wdone_cycle: got %0d expected %0d", obs_done_c, 2*FB*CPB + 1); end
    run_tx(2'd2, 32'h0080_01FE, -1);
    for (int k = 0; k < 3*FB; k++) begin
      logic [CPB-1:0] got, exp;
      for (int j = 0; j < CPB; j++) got[j] = obs_txd[1 + k*CPB + j];
      exp = {CPB{exp_bit(2'd2, 32'h0080_01FE, k)}};
      vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL b2b_b_bit%0d: txd %b expected %b", k, got, exp); end
    end
    vectors++; if (obs_done_c != 3*FB*CPB + 1) begin miscompares++; $display("FAIL b2b_b_wdone_cycle: got %0d expected %0d", obs_done_c, 3*FB*CPB + 1); end
  endtask

  task automatic test_rx_preloaded();
    logic ok, single;
    logic [31:0] w;
    rx_byte(8'hDE, 1'b1); rx_byte(8'hAD, 1'b1); rx_byte(8'hBE, 1'b1); rx_byte(8'hEF, 1'b1);
    idle(6);
    read_word(ok, w, single);
    vectors++; if (ok !== 1'b1)         begin miscompares++; $display("FAIL rx_pre_rdone: got %b expected 1", ok); end
    vectors++; if (w !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rx_pre_word: got %h expected deadbeef", w); end
    vectors++; if (single !== 1'b1)     begin miscompares++; $display("FAIL rx_pre_pulse: single-cycle/held %b expected 1", single); end
  endtask

  task automatic test_rx_errors();
    logic ok, single;
    logic [31:0] w;
    rxd = 1'b0; repeat (3) tick();
    idle(40);
    rx_byte(8'h55, 1'b0);
    idle(20);
    rx_byte(8'h01, 1'b1); rx_byte(8'h02, 1'b1); rx_byte(8'h03, 1'b1); rx_byte(8'h04, 1'b1);
    idle(6);
    read_word(ok, w, single);
    vectors++; if (ok !== 1'b1 || w !== 32'h0102_0304)
      begin miscompares++; $display("FAIL rx_err_word: rdone %b word %h expected 1 01020304", ok, w); end
    vectors++; if (rx_overrun !== 1'b0) begin miscompares++; $display("FAIL rx_err_overrun: got %b expected 0", rx_overrun); end
  endtask

  task automatic test_rx_renable_first();
    int c0;
    c0 = rdone_cnt;
    uart_renable = 1'b1; tick(); uart_renable = 1'b0;
    rx_byte(8'hDE, 1'b1); rx_byte(8'hAD, 1'b1); rx_byte(8'hBE, 1'b1);
    idle(8);
    vectors++; if (rdone_cnt != c0) begin miscompares++; $display("FAIL rx_first_blocked: %0d early rdone, expected 0", rdone_cnt - c0); end
    rx_byte(8'hEF, 1'b1);
    idle(8);
    vectors++; if (rdone_cnt != c0 + 1) begin miscompares++; $display("FAIL rx_first_rdone: %0d pulses expected 1", rdone_cnt - c0); end
    vectors++; if (uart_rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rx_first_word: got %h expected deadbeef", uart_rd); end
  endtask

  task automatic test_rx_overrun();
    logic ok, single;
    logic [31:0] w, exp;
    int c0;
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h10 + i), 1'b1);
    idle(4);
    vectors++; if (rx_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_at16: got %b expected 0", rx_overrun); end
    rx_byte(8'h20, 1'b1);
    idle(4);
    vectors++; if (rx_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_at17: got %b expected 1", rx_overrun); end
    for (int q = 0; q < 4; q++) begin
      exp = {8'(8'h10 + 4*q), 8'(8'h11 + 4*q), 8'(8'h12 + 4*q), 8'(8'h13 + 4*q)};
      read_word(ok, w, single);
      vectors++; if (ok !== 1'b1 || w !== exp)
        begin miscompares++; $display("FAIL ovr_word%0d: rdone %b word %h expected 1 %h", q, ok, w, exp); end
    end
    vectors++; if (rx_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b expected 1", rx_overrun); end
    c0 = rdone_cnt;
    uart_renable = 1'b1; tick(); uart_renable = 1'b0;
    idle(40);
    vectors++; if (rdone_cnt != c0) begin miscompares++; $display("FAIL ovr_empty_block: %0d rdone, expected 0", rdone_cnt - c0); end
  endtask

  task automatic test_reset_midframe();
    int w0, c0, low;
    logic e;
    rstn = 1'b0; tick(); tick(); rstn = 1'b1; tick();
    vectors++; if (rx_overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun_clear: got %b expected 0", rx_overrun); end
    uart_wsz = 2'd3; uart_wd = 32'h0; uart_wenable = 1'b1; tick(); uart_wenable = 1'b0;
    rx_byte(8'hAA, 1'b1); rx_byte(8'hBB, 1'b1);
    rxd = 1'b0; repeat (CPB) tick();
    rxd = 1'b0; repeat (CPB) tick();
    rxd = 1'b0; repeat (CPB) tick();
    rxd = 1'b1; repeat (CPB) tick();
    e = exp_bit(2'd3, 32'h0, (2*FB*CPB + 4*CPB) / CPB);
    vectors++; if (txd !== e || tx_busy !== 1'b1)
      begin miscompares++; $display("FAIL rst_pre_txd: txd %b busy %b expected %b 1", txd, tx_busy, e); end
    w0 = wdone_cnt;
    rstn = 1'b0; tick();
    vectors++; if (txd !== 1'b1) begin miscompares++; $display("FAIL rst_txd_next_edge: got %b expected 1", txd); end
    rxd = 1'b1; tick(); tick(); rstn = 1'b1;
    vectors++; if (tx_busy !== 1'b0 || uart_rd !== 32'h0)
      begin miscompares++; $display("FAIL rst_state: busy %b rd %h expected 0 00000000", tx_busy, uart_rd); end
    low = 0;
    repeat (400) begin tick(); if (txd !== 1'b1) low++; end
    vectors++; if (wdone_cnt != w0 || low != 0)
      begin miscompares++; $display("FAIL rst_no_wdone: wdone %0d txd-low %0d expected 0 0", wdone_cnt - w0, low); end
    c0 = rdone_cnt;
    uart_renable = 1'b1; tick(); uart_renable = 1'b0;
    rx_byte(8'hC0, 1'b1); rx_byte(8'hC1, 1'b1); rx_byte(8'hC2, 1'b1); rx_byte(8'hC3, 1'b1);
    idle(8);
    vectors++; if (rdone_cnt != c0 + 1) begin miscompares++; $display("FAIL rst_in_rdone: %0d pulses expected 1", rdone_cnt - c0); end
    vectors++; if (uart_rd !== 32'hC0C1_C2C3) begin miscompares++; $display("FAIL rst_in_word: got %h expected c0c1c2c3", uart_rd); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    logic ok, single;
    logic [31:0] w;
    run_tx(2'd0, 32'h0000_0003, -1);
    vectors++; if (obs_txd[1 + 9*CPB + CPB/2] !== 1'b0)
      begin miscompares++; $display("FAIL par_tx_bit: got %b expected 0", obs_txd[1 + 9*CPB + CPB/2]); end
    vectors++; if (obs_done_c != 11*CPB + 1)
      begin miscompares++; $display("FAIL par_tx_len: wdone cycle %0d expected %0d", obs_done_c, 11*CPB + 1); end
    rxd = 1'b0; repeat (CPB) tick();
    rxd = 1'b1; repeat (CPB) tick();
    rxd = 1'b0; repeat (7*CPB) tick();
    rxd = 1'b0; repeat (CPB) tick();
    rxd = 1'b1; repeat (CPB) tick();
    idle(10);
    rx_byte(8'h31, 1'b1); rx_byte(8'h32, 1'b1); rx_byte(8'h33, 1'b1); rx_byte(8'h34, 1'b1);
    idle(6);
    read_word(ok, w, single);
    vectors++; if (ok !== 1'b1 || w !== 32'h3132_3334)
      begin miscompares++; $display("FAIL par_rx_word: rdone %b word %h expected 1 31323334", ok, w); end
  endtask
`endif

  initial begin
    test_reset();
    test_tx_single();
    test_tx_word();
    test_back_to_back();
    test_rx_preloaded();
    test_rx_errors();
    test_rx_renable_first();
    test_rx_overrun();
    test_reset_midframe();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
